// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, grant and select definitions
// for the IF/MEM Wishbone bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_XFER,
        MEM_XFER
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_MEM
    } grant_t;

    localparam int DEF_SEL_WIDTH = 4;
    localparam logic [DEF_SEL_WIDTH-1:0] SEL_ALL = '1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts cycles of an outstanding bus transfer
// and flags expiry in the last allowed cycle.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone master between fetch and load/store.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_ack,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_ack,
    output logic                    im_busy,
    output logic                    mem_busy,
    output logic                    bus_err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [SW-1:0] SEL_FETCH = {SW{SEL_ALL[0]}};

    arb_state_t state, state_n;
    grant_t     last_grant;

    logic if_elig, mem_elig;
    logic grant_if, grant_mem;
    logic done, abort;
    logic wd_expire;

    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SW-1:0]         sel_q;

    // A port whose ack is showing cannot be re-accepted in that cycle.
    assign if_elig  = if_req & ~if_ack;
    assign mem_elig = mem_req & ~mem_ack;

    assign im_busy  = if_req & ~if_ack;
    assign mem_busy = mem_req & ~mem_ack;

    assign wb_cyc_o = (state != IDLE);
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_elig && (!if_elig || last_grant == GNT_IF)) begin
                    grant_mem = 1'b1;
                    state_n   = MEM_XFER;
                end else if (if_elig) begin
                    grant_if = 1'b1;
                    state_n  = IF_XFER;
                end
            end
            IF_XFER, MEM_XFER: begin
                if (wb_ack_i) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_IF;
            adr_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            sel_q      <= '0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            if (grant_mem) begin
                adr_q      <= mem_addr;
                we_q       <= mem_we;
                dat_q      <= mem_wdata;
                sel_q      <= mem_sel;
                last_grant <= GNT_MEM;
            end
            if (grant_if) begin
                adr_q      <= if_addr;
                we_q       <= 1'b0;
                dat_q      <= '0;
                sel_q      <= SEL_FETCH;
                last_grant <= GNT_IF;
            end
            if (done || abort) begin
                if (state == IF_XFER) begin
                    if_ack   <= 1'b1;
                    if_rdata <= abort ? '0 : wb_dat_i;
                end else begin
                    mem_ack <= 1'b1;
                    if (abort) begin
                        mem_rdata <= '0;
                    end else if (!we_q) begin
                        mem_rdata <= wb_dat_i;
                    end
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_clear, wd_enable, err_q;

    assign wd_clear  = (state == IDLE);
    assign wd_enable = (state != IDLE);

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign bus_err = err_q;
`else
    // No watchdog: transfers wait forever and the error output is constant 0.
    assign wd_expire = 1'b0;
    assign bus_err   = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors, corner sequences and randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif
    localparam logic [AW-1:0] IF_A  = 32'h1000_0000;
    localparam logic [AW-1:0] MEM_A = 32'h8040_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [SW-1:0] mem_sel = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          im_busy, mem_busy, bus_err;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .im_busy(im_busy), .mem_busy(mem_busy), .bus_err(bus_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Slave: acks after slv_wait stall cycles; random idle acks in rand_mode.
    int            slv_wait = 0;
    int            slv_cnt = 0;
    logic [DW-1:0] slv_data = '0;
    bit            rand_mode = 1'b0;

    always @(negedge clk) begin
        if (wb_cyc_o) begin
            if (slv_cnt >= slv_wait) begin
                wb_ack_i = 1'b1;
                wb_dat_i = slv_data;
            end else begin
                wb_ack_i = 1'b0;
                slv_cnt++;
            end
        end else begin
            slv_cnt  = 0;
            wb_ack_i = rand_mode && ($urandom_range(0, 7) == 0);
            wb_dat_i = $urandom;
            if (rand_mode) begin
                slv_wait = $urandom_range(0, 3);
                slv_data = $urandom;
            end
        end
    end

    // Reference model: owner 0=none 1=IF 2=MEM, tracked per bus transaction.
    int            m_owner = 0;
    int            m_last = 1;
    int            m_age = 0;
    bit            m_if_ack = 0, m_mem_ack = 0, m_err = 0;
    logic [DW-1:0] m_if_rd = '0, m_mem_rd = '0, m_dat = '0;
    logic [AW-1:0] m_adr = '0;
    logic          m_we = 1'b0;
    logic [SW-1:0] m_sel = '0;

    always @(posedge clk or posedge reset) begin : model
        bit n_if_ack, n_mem_ack, n_err, want_if, want_mem;
        if (reset) begin
            m_owner = 0; m_last = 1; m_age = 0;
            m_if_ack = 0; m_mem_ack = 0; m_err = 0;
            m_if_rd = '0; m_mem_rd = '0;
        end else begin
            n_if_ack = 0; n_mem_ack = 0; n_err = 0;
            if (m_owner == 0) begin
                want_if  = if_req && !m_if_ack;
                want_mem = mem_req && !m_mem_ack;
                if (want_mem && (!want_if || m_last == 1)) begin
                    m_owner = 2; m_last = 2; m_age = 0;
                    m_adr = mem_addr; m_we = mem_we;
                    m_dat = mem_wdata; m_sel = mem_sel;
                end else if (want_if) begin
                    m_owner = 1; m_last = 1; m_age = 0;
                    m_adr = if_addr; m_we = 1'b0; m_sel = '1;
                end
            end else begin
                m_age++;
                if (wb_ack_i) begin
                    if (m_owner == 1) begin
                        n_if_ack = 1; m_if_rd = wb_dat_i;
                    end else begin
                        n_mem_ack = 1;
                        if (!m_we) m_mem_rd = wb_dat_i;
                    end
                    m_owner = 0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (m_age == TMO) begin
                    if (m_owner == 1) begin
                        n_if_ack = 1; m_if_rd = '0;
                    end else begin
                        n_mem_ack = 1; m_mem_rd = '0;
                    end
                    n_err = 1;
                    m_owner = 0;
                end
`endif
            end
            m_if_ack = n_if_ack; m_mem_ack = n_mem_ack; m_err = n_err;
        end
    end

    always @(negedge clk) begin
        check("cyc", wb_cyc_o, m_owner != 0);
        check("stb", wb_stb_o, m_owner != 0);
        if (m_owner != 0) begin
            check("adr", wb_adr_o, m_adr);
            check("we", wb_we_o, m_we);
            check("sel", wb_sel_o, m_sel);
        end
        if (m_owner == 2) check("wdat", wb_dat_o, m_dat);
        check("if_ack", if_ack, m_if_ack);
        check("mem_ack", mem_ack, m_mem_ack);
        check("if_rdata", if_rdata, m_if_rd);
        check("mem_rdata", mem_rdata, m_mem_rd);
        check("bus_err", bus_err, m_err);
        #1;
        check("im_busy", im_busy, if_req && !m_if_ack);
        check("mem_busy", mem_busy, mem_req && !m_mem_ack);
    end

    task automatic reset_dut();
        reset = 1'b1;
        if_req = 1'b0; mem_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic xfer(input bit is_mem, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] sel, input int wt,
                        input logic [DW-1:0] sdata, output int lat,
                        output logic [AW-1:0] s_adr, output logic s_we,
                        output logic [SW-1:0] s_sel, output logic [DW-1:0] rd);
        bit got, seen;
        slv_wait = wt; slv_data = sdata;
        if (is_mem) begin
            mem_we = we; mem_addr = addr; mem_wdata = wdata;
            mem_sel = sel; mem_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        lat = 0; got = 0; seen = 0;
        s_adr = '0; s_we = 1'b0; s_sel = '0; rd = '0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (wb_cyc_o && !seen) begin
                seen = 1; s_adr = wb_adr_o; s_we = wb_we_o; s_sel = wb_sel_o;
            end
            if (is_mem ? mem_ack : if_ack) begin
                got = 1;
                rd = is_mem ? mem_rdata : if_rdata;
            end
        end
        check("xfer_done", got, 1'b1);
        mem_req = 1'b0; if_req = 1'b0;
    endtask

    typedef struct {
        bit            is_mem;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        int            wt;
        logic [DW-1:0] sdata;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
        logic [SW-1:0] exp_sel;
    } vec_t;

    task automatic grant_order(input int want, output int order[$]);
        logic prev;
        prev = 1'b0;
        order.delete();
        for (int c = 0; c < 60 && order.size() < want; c++) begin
            @(negedge clk);
            if (wb_cyc_o && !prev) order.push_back(wb_adr_o == MEM_A ? 2 : 1);
            prev = wb_cyc_o;
        end
    endtask

    initial begin
        vec_t          vecs[5];
        int            lat, order[$];
        logic [AW-1:0] s_adr;
        logic          s_we;
        logic [SW-1:0] s_sel;
        logic [DW-1:0] rd;
        bit            saw;

        vecs[0] = '{0, 0, 32'h8000_0000, 32'h0, 4'hF, 0, 32'h0000_0013,
                    2, 32'h0000_0013, 4'hF};
        vecs[1] = '{1, 0, MEM_A, 32'h0, 4'hF, 0, 32'hCAFE_F00D,
                    2, 32'hCAFE_F00D, 4'hF};
        vecs[2] = '{1, 1, 32'h8040_0010, 32'hDEAD_BEEF, 4'b0011, 0,
                    32'h1234_5678, 2, 32'hCAFE_F00D, 4'b0011};
        vecs[3] = '{0, 0, 32'h8000_0004, 32'h0, 4'hF, 3, 32'h0000_A5A5,
                    5, 32'h0000_A5A5, 4'hF};
        vecs[4] = '{1, 0, 32'h8040_0020, 32'h0, 4'b1000, 1, 32'h0102_0304,
                    3, 32'h0102_0304, 4'b1000};

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_adr", wb_adr_o, '0);
        check("rst_sel", wb_sel_o, '0);
        check("rst_acks", {if_ack, mem_ack, bus_err}, 3'b000);
        check("rst_rdata", {if_rdata, mem_rdata}, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            xfer(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].sel, vecs[i].wt, vecs[i].sdata,
                 lat, s_adr, s_we, s_sel, rd);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_adr", i), s_adr, vecs[i].addr);
            check($sformatf("v%0d_we", i), s_we, vecs[i].we);
            check($sformatf("v%0d_sel", i), s_sel, vecs[i].exp_sel);
            @(negedge clk);
        end

        // Simultaneous requests after reset: MEM first, then IF.
        reset_dut();
        slv_wait = 0; slv_data = 32'h0000_0055;
        if_addr = IF_A; mem_addr = MEM_A; mem_we = 1'b0; mem_sel = '1;
        if_req = 1'b1; mem_req = 1'b1;
        fork
            grant_order(2, order);
            begin
                for (int c = 0; c < 60 && (if_req || mem_req); c++) begin
                    @(negedge clk);
                    if (if_ack) if_req = 1'b0;
                    if (mem_ack) mem_req = 1'b0;
                end
            end
        join
        check("simul_cnt", order.size(), 2);
        check("simul_first", order.size() > 0 ? order[0] : 0, 2);
        check("simul_second", order.size() > 1 ? order[1] : 0, 1);
        if_req = 1'b0; mem_req = 1'b0;
        repeat (3) @(negedge clk);

        // Both held for four transfers: strict alternation.
        reset_dut();
        if_req = 1'b1; mem_req = 1'b1;
        grant_order(4, order);
        if_req = 1'b0; mem_req = 1'b0;
        check("alt_cnt", order.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("alt_g%0d", k),
                  order.size() > k ? order[k] : 0, (k % 2 == 0) ? 2 : 1);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a MEM transfer.
        reset_dut();
        slv_wait = 1_000_000;
        mem_addr = MEM_A; mem_we = 1'b0; mem_req = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_cyc_up", wb_cyc_o, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("ar_cyc_async", wb_cyc_o, 1'b0);
        check("ar_stb_async", wb_stb_o, 1'b0);
        mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ack) saw = 1'b1;
        end
        check("ar_no_ack", saw, 1'b0);
        check("ar_idle", wb_cyc_o, 1'b0);
        slv_wait = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        reset_dut();
        xfer(1, 0, MEM_A, '0, 4'hF, 0, 32'h0000_0055, lat, s_adr, s_we, s_sel, rd);
        check("to_pre_rd", rd, 32'h0000_0055);
        @(negedge clk);
        xfer(1, 0, MEM_A, '0, 4'hF, 1_000_000, 32'h0, lat, s_adr, s_we, s_sel, rd);
        check("to_lat", lat, TMO + 1);
        check("to_rdata", rd, '0);
        check("to_err", bus_err, 1'b1);
        @(negedge clk);
        check("to_err_pulse", bus_err, 1'b0);
        slv_wait = 0;
`endif

        // Randomized traffic against the model.
        reset_dut();
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (if_req) begin
                if (if_ack) begin
                    if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                    else if_addr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (mem_req) begin
                if (mem_ack) begin
                    if ($urandom_range(0, 1) == 0) begin
                        mem_req = 1'b0;
                    end else begin
                        mem_addr = $urandom; mem_we = 1'($urandom);
                        mem_wdata = $urandom; mem_sel = SW'($urandom);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                mem_req = 1'b1; mem_addr = $urandom; mem_we = 1'($urandom);
                mem_wdata = $urandom; mem_sel = SW'($urandom);
            end
        end
        rand_mode = 1'b0;
        if_req = 1'b0; mem_req = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
